// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator sequencer: command op encodings,
// FSM state encodings and the default data width.
package acc_pkg;

  localparam int ACC_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/acc_flag_gen.sv
// Combinational flag/next-value generator for the accumulator.
// Optional feature macro: ACC_SATURATE_EN (saturate instead of modulo wrap).
// C and V always describe the raw adder result; Z follows the value written.
module acc_flag_gen
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic [WIDTH-1:0] next_acc
);

  logic [WIDTH-1:0] b_eff;

  // Raw flags plus the (optionally saturated) value destined for acc
  always_comb begin
    b_eff = sub ? ~b : b;
    c     = cout;
    v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
`ifdef ACC_SATURATE_EN
    // ADD carry-out clamps high, SUB borrow (cout=0) clamps low
    if (!sub && cout)
      next_acc = {WIDTH{1'b1}};
    else if (sub && !cout)
      next_acc = '0;
    else
      next_acc = result;
`else
    next_acc = result;
`endif
    z = (next_acc == '0);
  end

endmodule

// File: rtl/accumulator_sequencer.sv
// Accumulator sequencer: accepts CLR/LOAD/ADD/SUB commands over valid/ready,
// drives an external combinational adder during EXEC and captures its
// result and status flags. Optional feature macro: ACC_SATURATE_EN
// (handled inside acc_flag_gen).
module accumulator_sequencer
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_cout,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_reg, op_next;
  logic             sub_reg, sub_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             z_reg, z_next;
  logic             c_reg, c_next;
  logic             v_reg, v_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] gen_acc;
  logic             gen_z, gen_c, gen_v;

  acc_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .a        (add_a),
    .b        (add_b),
    .sub      (add_sub),
    .result   (add_result),
    .cout     (add_cout),
    .z        (gen_z),
    .c        (gen_c),
    .v        (gen_v),
    .next_acc (gen_acc)
  );

  // Adder is only driven while executing; quiet zeros otherwise
  always_comb begin
    cmd_ready = (state_reg == ST_IDLE);
    add_a     = (state_reg == ST_EXEC) ? acc_reg : '0;
    add_b     = (state_reg == ST_EXEC) ? op_reg  : '0;
    add_sub   = (state_reg == ST_EXEC) ? sub_reg : 1'b0;
    acc       = acc_reg;
    flag_z    = z_reg;
    flag_c    = c_reg;
    flag_v    = v_reg;
    done      = done_reg;
  end

  // Next-state and register-update decisions
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    sub_next   = sub_reg;
    acc_next   = acc_reg;
    z_next     = z_reg;
    c_next     = c_reg;
    v_next     = v_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_CLR: begin
              acc_next  = '0;
              z_next    = 1'b1;
              c_next    = 1'b0;
              v_next    = 1'b0;
              done_next = 1'b1;
            end
            OP_LOAD: begin
              acc_next  = cmd_operand;
              z_next    = (cmd_operand == '0);
              c_next    = 1'b0;
              v_next    = 1'b0;
              done_next = 1'b1;
            end
            default: begin
              op_next    = cmd_operand;
              sub_next   = (op_t'(cmd_op) == OP_SUB);
              state_next = ST_EXEC;
            end
          endcase
        end
      end
      ST_EXEC: begin
        acc_next   = gen_acc;
        z_next     = gen_z;
        c_next     = gen_c;
        v_next     = gen_v;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      sub_reg   <= 1'b0;
      acc_reg   <= '0;
      z_reg     <= 1'b1;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      sub_reg   <= sub_next;
      acc_reg   <= acc_next;
      z_reg     <= z_next;
      c_reg     <= c_next;
      v_reg     <= v_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer with a behavioural model of
// the external 4-bit adder/subtractor. Expected results are queued at
// command acceptance and popped when done pulses.
module tb_accumulator_sequencer;
  import acc_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] acc;
    logic         z;
    logic         c;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_operand = '0;
  logic [W-1:0] add_a, add_b, add_result;
  logic         add_sub, add_cout;
  logic [W-1:0] acc;
  logic         flag_z, flag_c, flag_v, done;

  int vectors = 0;
  int miscompares = 0;

  res_t         exp_q[$];
  logic [W-1:0] m_acc = '0;

  // observations captured by drive_cmd
  res_t         obs;
  int           obs_lat;
  logic [W-1:0] obs_a, obs_b;
  logic         obs_sub, obs_ready1;

  always #5 clk = ~clk;

  accumulator_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .add_a(add_a), .add_b(add_b),
    .add_sub(add_sub), .add_result(add_result), .add_cout(add_cout),
    .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .done(done)
  );

  // Adder model: A + (sub ? ~B : B) + sub
  logic [W-1:0] beff_m;
  logic [W:0]   sum_m;
  always_comb begin
    beff_m     = add_sub ? ~add_b : add_b;
    sum_m      = {1'b0, add_a} + {1'b0, beff_m} + {{W{1'b0}}, add_sub};
    add_result = sum_m[W-1:0];
    add_cout   = sum_m[W];
  end

  // Reference model of one command applied to m_acc
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] cur);
    res_t         r;
    logic [W-1:0] be;
    logic [W:0]   s;
    logic         sb;
    r = '0;
    case (op)
      2'b00: begin r.acc = '0; r.z = 1'b1; end
      2'b01: begin r.acc = x; r.z = (x == '0); end
      default: begin
        sb  = (op == 2'b11);
        be  = sb ? ~x : x;
        s   = {1'b0, cur} + {1'b0, be} + {{W{1'b0}}, sb};
        r.c = s[W];
        r.v = (cur[W-1] == be[W-1]) && (s[W-1] != cur[W-1]);
        r.acc = s[W-1:0];
`ifdef ACC_SATURATE_EN
        if (!sb && s[W]) r.acc = '1;
        if (sb && !s[W]) r.acc = '0;
`endif
        r.z = (r.acc == '0);
      end
    endcase
    return r;
  endfunction

  // Drive one command, wait (bounded) for acceptance and done; record results
  task automatic drive_cmd(input logic [1:0] op, input logic [W-1:0] x);
    res_t e;
    bit   acc_ok;
    @(negedge clk);
    cmd_op = op; cmd_operand = x; cmd_valid = 1'b1;
    acc_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) begin acc_ok = 1'b1; break; end
      @(negedge clk);
    end
    obs_lat = -1;
    if (!acc_ok) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(op, x, m_acc);
    exp_q.push_back(e);
    m_acc = e.acc;
    #1 cmd_valid = 1'b0;
    for (int l = 1; l <= 8; l++) begin
      @(negedge clk);
      if (l == 1) begin
        obs_a = add_a; obs_b = add_b; obs_sub = add_sub; obs_ready1 = cmd_ready;
      end
      if (done) begin
        obs_lat = l;
        obs = '{acc: acc, z: flag_z, c: flag_c, v: flag_v};
        break;
      end
    end
  endtask

  task automatic test_reset();
    res_t got;
    @(negedge clk);
    got = '{acc: acc, z: flag_z, c: flag_c, v: flag_v};
    vectors++;
    if (got !== res_t'({4'h0, 3'b100}) || done !== 1'b0 || add_a !== 0 || add_b !== 0 || add_sub !== 0) begin
      miscompares++;
      $display("FAIL reset_values: got acc=%h z%b c%b v%b done=%b a=%h b=%h s=%b, want acc=0 z1 c0 v0 done=0 a=0 b=0 s=0",
               acc, flag_z, flag_c, flag_v, done, add_a, add_b, add_sub);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    // mid-run reset after a LOAD
    drive_cmd(2'b01, 4'h9);
    void'(exp_q.pop_front());
    #2 rst = 1'b1; m_acc = '0;
    #1;
    vectors++;
    if (acc !== 4'h0 || flag_z !== 1'b1 || flag_c !== 1'b0 || flag_v !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midrun: got acc=%h z%b c%b v%b done=%b want acc=0 z1 c0 v0 done=0",
               acc, flag_z, flag_c, flag_v, done);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midrun_ready: got %b want 1", cmd_ready);
    end
  endtask

  // LOAD x then ADD/SUB y; checks EXEC adder drive, latency and result
  task automatic test_arith(input string name, input logic [W-1:0] x,
                            input logic [1:0] op, input logic [W-1:0] y);
    res_t e;
    drive_cmd(2'b01, x);
    e = exp_q.pop_front();
    vectors++;
    if (obs_lat !== 1 || obs !== e) begin
      miscompares++;
      $display("FAIL %s_load: got lat=%0d acc=%h z%b c%b v%b want lat=1 acc=%h z%b c%b v%b",
               name, obs_lat, obs.acc, obs.z, obs.c, obs.v, e.acc, e.z, e.c, e.v);
    end
    drive_cmd(op, y);
    e = exp_q.pop_front();
    vectors++;
    if (obs_a !== x || obs_b !== y || obs_sub !== (op == 2'b11) || obs_ready1 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_exec: got a=%h b=%h sub=%b ready=%b want a=%h b=%h sub=%b ready=0",
               name, obs_a, obs_b, obs_sub, obs_ready1, x, y, (op == 2'b11));
    end
    vectors++;
    if (obs_lat !== 2 || obs !== e) begin
      miscompares++;
      $display("FAIL %s_result: got lat=%0d acc=%h z%b c%b v%b want lat=2 acc=%h z%b c%b v%b",
               name, obs_lat, obs.acc, obs.z, obs.c, obs.v, e.acc, e.z, e.c, e.v);
    end
    $display("%s: acc=%h z%b c%b v%b lat=%0d", name, obs.acc, obs.z, obs.c, obs.v, obs_lat);
  endtask

  task automatic test_back_to_back();
    res_t e;
    int   accepts = 0, dones = 0;
    bit   pend;
    drive_cmd(2'b00, 4'h0);
    e = exp_q.pop_front();
    vectors++;
    if (obs_lat !== 1 || obs !== e) begin
      miscompares++;
      $display("FAIL b2b_clr: got lat=%0d acc=%h want lat=1 acc=%h", obs_lat, obs.acc, e.acc);
    end
    @(negedge clk);
    cmd_op = 2'b10; cmd_operand = 4'h1; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && dones < 3; cyc++) begin
      pend = cmd_valid && cmd_ready;
      @(posedge clk);
      if (pend) begin
        accepts++;
        e = model(2'b10, 4'h1, m_acc);
        exp_q.push_back(e);
        m_acc = e.acc;
        if (accepts == 3) #1 cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (pend) begin
        vectors++;
        if (cmd_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready_exec: got %b want 0", cmd_ready);
        end
      end
      if (done) begin
        dones++;
        e = exp_q.pop_front();
        vectors++;
        if (acc !== e.acc || flag_z !== e.z || flag_c !== e.c || flag_v !== e.v) begin
          miscompares++;
          $display("FAIL b2b_done%0d: got acc=%h z%b c%b v%b want acc=%h z%b c%b v%b",
                   dones, acc, flag_z, flag_c, flag_v, e.acc, e.z, e.c, e.v);
        end
        $display("b2b done %0d: acc=%h", dones, acc);
      end
    end
    cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    vectors++;
    if (dones !== 3 || acc !== 4'h3) begin
      miscompares++;
      $display("FAIL b2b_count: got dones=%0d acc=%h want dones=3 acc=3", dones, acc);
    end
  endtask

  task automatic test_reset_mid_exec();
    int dones = 0;
    @(negedge clk);
    cmd_op = 2'b10; cmd_operand = 4'h1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b0 || add_a !== 4'h3) begin
      miscompares++;
      $display("FAIL rst_exec_enter: got ready=%b a=%h want ready=0 a=3", cmd_ready, add_a);
    end
    rst = 1'b1; m_acc = '0;
    @(posedge clk);
    @(negedge clk);
    if (done) dones++;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    vectors++;
    if (dones !== 0 || acc !== 4'h0 || flag_z !== 1'b1 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_exec_abort: got dones=%0d acc=%h z%b ready=%b want dones=0 acc=0 z1 ready=1",
               dones, acc, flag_z, cmd_ready);
    end
    $display("rst mid-exec: acc=%h dones=%0d", acc, dones);
  endtask

  initial begin
    test_reset();
    test_arith("load5_add3", 4'h5, 2'b10, 4'h3);
    test_arith("load3_sub5", 4'h3, 2'b11, 4'h5);
    test_arith("load7_sub7", 4'h7, 2'b11, 4'h7);
    test_arith("loadF_add1", 4'hF, 2'b10, 4'h1);
    test_arith("load0_sub1", 4'h0, 2'b11, 4'h1);
    test_arith("loadA_add7", 4'hA, 2'b10, 4'h7);
    test_back_to_back();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
